// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared types and default widths for the NCO sweep controller.
// The DOWN state is only reached when NCO_SWEEP_BIDIR_EN is defined.
package nco_sweep_pkg;

  localparam int NCO_N  = 32;  // control-word width, matches the NCO
  localparam int NCO_DW = 16;  // dwell counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// nco_dwell_timer: loadable down-counter that pulses tc when it reaches zero
// while enabled, and reloads itself so each frequency lasts reload_val+1 cycles.
module nco_dwell_timer
  import nco_sweep_pkg::*;
#(
  parameter int DW = NCO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          clr,
  input  logic [DW-1:0] load_val,
  input  logic [DW-1:0] reload_val,
  output logic          tc
);

  logic [DW-1:0] cnt_r;

  assign tc = en && (cnt_r == {DW{1'b0}});

  // Counter: clear beats load beats count; reload on terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {DW{1'b0}};
    end else if (clr) begin
      cnt_r <= {DW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      if (cnt_r == {DW{1'b0}}) begin
        cnt_r <= reload_val;
      end else begin
        cnt_r <= cnt_r - {{(DW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/nco_sweep.sv
// nco_sweep: stepped linear chirp generator feeding the NCO control word.
// Optional macro NCO_SWEEP_BIDIR_EN adds a DOWN leg back to f_start.
// ctrl never wraps: the step sum is formed one bit wider and clipped.
module nco_sweep
  import nco_sweep_pkg::*;
#(
  parameter int N  = NCO_N,
  parameter int DW = NCO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  f_start,
  input  logic [N-1:0]  f_stop,
  input  logic [N-1:0]  f_step,
  input  logic [DW-1:0] dwell,
  output logic [N-1:0]  ctrl,
  output logic          busy,
  output logic          done
);

  sweep_state_t  state_r;
  logic [N-1:0]  ctrl_r;
  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  f_stop_r;
  logic [N-1:0]  f_step_r;
  logic [DW-1:0] dwell_r;

  logic [N:0]    sum_s;
  logic [N-1:0]  up_next_s;
  logic          up_at_end_s;
  logic          reverse_s;
  logic          finish_s;
  logic          tc_s;
  logic          load_s;
  logic          clr_s;
  logic [N-1:0]  dn_next_s;

`ifdef NCO_SWEEP_BIDIR_EN
  logic [N-1:0]  f_start_r;
  logic [N:0]    diff_s;
  logic          dn_at_end_s;

  // Down step: subtract in N+1 bits, clip at f_start on underflow or overshoot.
  always_comb begin
    diff_s = {1'b0, ctrl_r} - {1'b0, f_step_r};
    if ((f_step_r == {N{1'b0}}) || diff_s[N] || (diff_s[N-1:0] <= f_start_r)) begin
      dn_next_s = f_start_r;
    end else begin
      dn_next_s = diff_s[N-1:0];
    end
    dn_at_end_s = (ctrl_r <= f_start_r);
    reverse_s   = (f_stop_r > f_start_r);
  end
`else
  assign dn_next_s = ctrl_r;
  assign reverse_s = 1'b0;
`endif

  // Up step: add in N+1 bits, clip at f_stop on carry or overshoot; zero step jumps.
  always_comb begin
    sum_s = {1'b0, ctrl_r} + {1'b0, f_step_r};
    if ((f_step_r == {N{1'b0}}) || sum_s[N] || (sum_s[N-1:0] >= f_stop_r)) begin
      up_next_s = f_stop_r;
    end else begin
      up_next_s = sum_s[N-1:0];
    end
    up_at_end_s = (ctrl_r >= f_stop_r);
  end

  // Decide whether the current step event ends the sweep.
  always_comb begin
    finish_s = 1'b0;
    case (state_r)
      UP:      finish_s = up_at_end_s && !reverse_s;
`ifdef NCO_SWEEP_BIDIR_EN
      DOWN:    finish_s = dn_at_end_s;
`endif
      default: finish_s = 1'b0;
    endcase
  end

  assign load_s = (state_r == IDLE) && start && !stop;
  assign clr_s  = (state_r != IDLE) && (stop || (tc_s && finish_s));

  nco_dwell_timer #(.DW(DW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (busy_r),
    .load       (load_s),
    .clr        (clr_s),
    .load_val   (dwell),
    .reload_val (dwell_r),
    .tc         (tc_s)
  );

  // Sweep FSM with registered ctrl/busy/done and parameter shadows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ctrl_r   <= {N{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      f_stop_r <= {N{1'b0}};
      f_step_r <= {N{1'b0}};
      dwell_r  <= {DW{1'b0}};
`ifdef NCO_SWEEP_BIDIR_EN
      f_start_r <= {N{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            f_stop_r <= f_stop;
            f_step_r <= f_step;
            dwell_r  <= dwell;
`ifdef NCO_SWEEP_BIDIR_EN
            f_start_r <= f_start;
`endif
            ctrl_r  <= f_start;
            busy_r  <= 1'b1;
            state_r <= UP;
          end else begin
            state_r <= IDLE;
          end
        end
        UP: begin
          if (stop) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (tc_s) begin
            if (finish_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else if (up_at_end_s) begin
              ctrl_r  <= dn_next_s;
              state_r <= DOWN;
            end else begin
              ctrl_r <= up_next_s;
            end
          end else begin
            state_r <= UP;
          end
        end
`ifdef NCO_SWEEP_BIDIR_EN
        DOWN: begin
          if (stop) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (tc_s) begin
            if (finish_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              ctrl_r <= dn_next_s;
            end
          end else begin
            state_r <= DOWN;
          end
        end
`endif
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ctrl = ctrl_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_nco_sweep.sv
// tb_nco_sweep: randomized and directed checks of nco_sweep against a
// value-list model built from the sweep rules.
module tb_nco_sweep;

  localparam int N  = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [N-1:0]  f_start;
  logic [N-1:0]  f_stop;
  logic [N-1:0]  f_step;
  logic [DW-1:0] dwell;
  logic [N-1:0]  ctrl;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_ctrl;

  nco_sweep dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .ctrl    (ctrl),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // List of distinct control words the sweep should visit, in order.
  task automatic build_model(input longint fs, input longint fe, input longint st);
    longint v;
    exp_q.delete();
    v = fs;
    exp_q.push_back(32'(v));
    while (v < fe) begin
      if (st == 0 || v + st >= fe) v = fe;
      else v = v + st;
      exp_q.push_back(32'(v));
    end
`ifdef NCO_SWEEP_BIDIR_EN
    if (fe > fs) begin
      while (v > fs) begin
        if (st == 0 || v - st <= fs) v = fs;
        else v = v - st;
        exp_q.push_back(32'(v));
      end
    end
`endif
  endtask

  task automatic run_sweep(input logic [N-1:0] fs, input logic [N-1:0] fe, input logic [N-1:0] st,
                           input logic [DW-1:0] dw, input int stop_at, input int rst_at);
    int len;
    int hold;
    logic [N-1:0] want;
    build_model({32'd0, fs}, {32'd0, fe}, {32'd0, st});
    hold = int'(dw) + 1;
    len  = exp_q.size() * hold;
    @(posedge clk); #1;
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = DW'($urandom);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      want = exp_q[i / hold];
      check("ctrl", ctrl, want);
      check("busy", {31'd0, busy}, 32'd1);
      check("done_low", {31'd0, done}, 32'd0);
      if (i == stop_at) begin
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_done", {31'd0, done}, 32'd0);
        check("stop_ctrl", ctrl, want);
        repeat (3) begin
          @(negedge clk);
          check("frozen_ctrl", ctrl, want);
          check("frozen_done", {31'd0, done}, 32'd0);
        end
        last_ctrl = want;
        return;
      end
      if (i == rst_at) begin
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("rst_ctrl", ctrl, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_ctrl", ctrl, 32'd0);
        last_ctrl = 32'd0;
        return;
      end
      start = (i < len - 1) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    want = exp_q[exp_q.size() - 1];
    check("done_pulse", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ctrl", ctrl, want);
    @(negedge clk);
    check("done_once", {31'd0, done}, 32'd0);
    check("hold_ctrl", ctrl, want);
    last_ctrl = want;
  endtask

  initial begin
    logic [N-1:0] fs, fe, st;
    logic [DW-1:0] dw;
    int sel;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    f_start = 32'd0; f_stop = 32'd0; f_step = 32'd0; dwell = 16'd0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", ctrl, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    last_ctrl = 32'd0;

    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, -1, -1);
    run_sweep(32'd100, 32'd125, 32'd10, 16'd0, -1, -1);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, -1, -1);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 4, -1);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, -1, -1);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, -1, 5);

    // stop together with start in IDLE: no sweep begins.
    @(posedge clk); #1;
    f_start = 32'd55; f_stop = 32'd99; f_step = 32'd1; dwell = 16'd0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("stopwins_busy", {31'd0, busy}, 32'd0);
    check("stopwins_ctrl", ctrl, last_ctrl);

    run_sweep(32'd200, 32'd150, 32'd5, 16'd1, -1, -1);
    run_sweep(32'd50, 32'd50, 32'd7, 16'd0, -1, -1);
    run_sweep(32'd10, 32'd90, 32'd0, 16'd1, -1, -1);

    for (int k = 0; k < 25; k++) begin
      sel = int'($urandom % 4);
      if (sel == 0) begin
        fs = 32'hFFFF_FF00 | N'($urandom_range(0, 255));
        fe = 32'hFFFF_FF00 | N'($urandom_range(0, 255));
        st = N'($urandom_range(8, 128));
      end else begin
        fs = N'($urandom_range(0, 200));
        fe = N'($urandom_range(0, 300));
        st = (sel == 3) ? 32'd0 : N'($urandom_range(3, 40));
      end
      dw = DW'($urandom_range(0, 3));
      run_sweep(fs, fe, st, dw, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
